// File: rtl/mixer_3.sv
// -----------------------------------------------------------------------------
// mixer_3 -- time-multiplexed stereo voice mixer
//
// Takes one oscillator slot (voice vx, oscillator ox) per cycle from the
// slot-serial oscillator stage. Each slot's sine sample is scaled by envelope,
// per-oscillator level and per-oscillator pan, then summed into left/right
// accumulators. On the last slot of a frame the sums are scaled by master
// volume, shifted, saturated and presented as a stereo sample with a
// one-cycle valid strobe.
//
// Ports
//   sCLK_XVXENVS  clock, rising edge
//   reset_data_N  asynchronous active-low reset
//   slot_valid / slot_vx / slot_ox / sine_in / level_mul   slot input
//   reg_we / reg_com_sel / reg_adr / reg_wdata             register writes
//   flag_clr      clears clip_l, clip_r, frame_err (a same-cycle set wins)
//   lsound_out / rsound_out   saturated signed stereo sample
//   sound_valid   one-cycle pulse when a new sample is loaded
//   clip_l / clip_r           sticky saturation flags
//   frame_err     sticky flag: last slot seen with wrong slot count
// -----------------------------------------------------------------------------
module mixer_3 #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 2,
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 24,
  parameter int ACC_WIDTH = 64,
  parameter int OUT_SHIFT = 21
) (
  input  logic                        sCLK_XVXENVS,
  input  logic                        reset_data_N,
  input  logic                        slot_valid,
  input  logic [V_WIDTH-1:0]          slot_vx,
  input  logic [O_WIDTH-1:0]          slot_ox,
  input  logic signed [IN_WIDTH-1:0]  sine_in,
  input  logic signed [7:0]           level_mul,
  input  logic                        reg_we,
  input  logic                        reg_com_sel,
  input  logic [6:0]                  reg_adr,
  input  logic [7:0]                  reg_wdata,
  input  logic                        flag_clr,
  output logic signed [OUT_WIDTH-1:0] lsound_out,
  output logic signed [OUT_WIDTH-1:0] rsound_out,
  output logic                        sound_valid,
  output logic                        clip_l,
  output logic                        clip_r,
  output logic                        frame_err
);

  localparam int FRAME_SLOTS = VOICES * V_OSC;
  localparam int CNT_W       = $clog2(FRAME_SLOTS + 1) + 1;

  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic signed [OUT_WIDTH-1:0] value;
    logic                        clipped;
  } sat_t;

  function automatic sat_t saturate(input logic signed [ACC_WIDTH-1:0] v);
    sat_t r;
    if (v > OUT_MAX) begin
      r.value   = OUT_MAX[OUT_WIDTH-1:0];
      r.clipped = 1'b1;
    end else if (v < OUT_MIN) begin
      r.value   = OUT_MIN[OUT_WIDTH-1:0];
      r.clipped = 1'b1;
    end else begin
      r.value   = v[OUT_WIDTH-1:0];
      r.clipped = 1'b0;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Register banks
  // ---------------------------------------------------------------------------
  logic signed [7:0] osc_lvl [V_OSC];
  logic        [7:0] osc_pan [V_OSC];
  logic signed [7:0] m_vol;

  // NOTE: these small arrays are configuration registers whose power-up values
  // are relied on by software, so they are reset explicitly element by element;
  // a large data RAM would normally be left unreset.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      for (int i = 0; i < V_OSC; i++) begin
        osc_lvl[i] <= (i < 2) ? 8'sh40 : 8'sh00;
        osc_pan[i] <= 8'h40;
      end
      m_vol <= 8'sh40;
    end else if (reg_we) begin
      if (reg_com_sel) begin
        if (reg_adr == 7'd1) m_vol <= $signed(reg_wdata);
      end else begin
        // Oscillator index in the upper address bits; indices >= V_OSC match
        // no entry and are therefore ignored.
        for (int i = 0; i < V_OSC; i++) begin
          if (int'(reg_adr[6:4]) == i) begin
            if (reg_adr[3:0] == 4'd2) osc_lvl[i] <= $signed(reg_wdata);
            if (reg_adr[3:0] == 4'd7) osc_pan[i] <= reg_wdata;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic                        slot_last;
  logic                        s1_valid, s1_last, s2_valid, s2_last, s3_valid, s3_last;
  logic [O_WIDTH-1:0]          s1_ox, s2_ox;
  logic signed [ACC_WIDTH-1:0] s1_a, s2_b, s3_l, s3_r;
  logic signed [ACC_WIDTH-1:0] acc_l, acc_r;

  logic signed [ACC_WIDTH-1:0] s1_a_next, s2_b_next, gain_l, gain_r;
  logic signed [ACC_WIDTH-1:0] sum_l, sum_r, shf_l, shf_r;
  logic [6:0]                  pan_p;
  sat_t                        sat_l, sat_r;

  assign slot_last = (slot_vx == V_WIDTH'(VOICES - 1)) &&
                     (slot_ox == O_WIDTH'(V_OSC - 1));

  // NOTE: every variable written here gets a value on every path (most are
  // unconditional), so this block stays purely combinational with no latches.
  always_comb begin
    s1_a_next = ACC_WIDTH'(sine_in) * ACC_WIDTH'(level_mul);
    s2_b_next = s1_a * ACC_WIDTH'(osc_lvl[s1_ox]);
    // Pan values above 127 clamp to hard right.
    pan_p     = (osc_pan[s2_ox] > 8'd127) ? 7'd127 : osc_pan[s2_ox][6:0];
    gain_r    = ACC_WIDTH'(pan_p);
    gain_l    = ACC_WIDTH'(7'd127 - pan_p);
    // Frame-end path: the last slot's own term joins the sum before scaling.
    sum_l     = acc_l + s3_l;
    sum_r     = acc_r + s3_r;
    shf_l     = (sum_l * ACC_WIDTH'(m_vol)) >>> OUT_SHIFT;
    shf_r     = (sum_r * ACC_WIDTH'(m_vol)) >>> OUT_SHIFT;
    sat_l     = saturate(shf_l);
    sat_r     = saturate(shf_r);
  end

  // NOTE: all state below uses non-blocking assignments so every stage samples
  // the previous stage's value from before the edge, not the freshly updated one.
  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      s1_valid <= 1'b0;  s1_last <= 1'b0;  s1_ox <= '0;  s1_a <= '0;
      s2_valid <= 1'b0;  s2_last <= 1'b0;  s2_ox <= '0;  s2_b <= '0;
      s3_valid <= 1'b0;  s3_last <= 1'b0;  s3_l  <= '0;  s3_r <= '0;
    end else begin
      s1_valid <= slot_valid;
      s1_last  <= slot_valid & slot_last;
      s1_ox    <= slot_ox;
      s1_a     <= s1_a_next;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_ox    <= s1_ox;
      s2_b     <= s2_b_next;
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      s3_l     <= s2_b * gain_l;
      s3_r     <= s2_b * gain_r;
    end
  end

  // Accumulation and frame output
  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      acc_l       <= '0;
      acc_r       <= '0;
      lsound_out  <= '0;
      rsound_out  <= '0;
      sound_valid <= 1'b0;
      clip_l      <= 1'b0;
      clip_r      <= 1'b0;
    end else begin
      sound_valid <= 1'b0;
      clip_l      <= clip_l & ~flag_clr;
      clip_r      <= clip_r & ~flag_clr;
      if (s3_valid) begin
        if (s3_last) begin
          acc_l       <= '0;
          acc_r       <= '0;
          lsound_out  <= sat_l.value;
          rsound_out  <= sat_r.value;
          sound_valid <= 1'b1;
          if (sat_l.clipped) clip_l <= 1'b1;
          if (sat_r.clipped) clip_r <= 1'b1;
        end else begin
          acc_l <= sum_l;
          acc_r <= sum_r;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot counter: counts valid slots up to and including the last slot
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] slot_cnt, cnt_inc;

  assign cnt_inc = (slot_cnt == {CNT_W{1'b1}}) ? slot_cnt : slot_cnt + 1'b1;

  always_ff @(posedge sCLK_XVXENVS or negedge reset_data_N) begin
    if (!reset_data_N) begin
      slot_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_err & ~flag_clr;
      if (slot_valid) begin
        if (slot_last) begin
          slot_cnt <= '0;
          if (cnt_inc != CNT_W'(FRAME_SLOTS)) frame_err <= 1'b1;
        end else begin
          slot_cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mixer_3.sv
// -----------------------------------------------------------------------------
// tb_mixer_3 -- directed self-checking bench for mixer_3
// -----------------------------------------------------------------------------
module tb_mixer_3;

  logic               sCLK_XVXENVS;
  logic               reset_data_N;
  logic               slot_valid;
  logic [2:0]         slot_vx;
  logic [1:0]         slot_ox;
  logic signed [16:0] sine_in;
  logic signed [7:0]  level_mul;
  logic               reg_we;
  logic               reg_com_sel;
  logic [6:0]         reg_adr;
  logic [7:0]         reg_wdata;
  logic               flag_clr;
  logic signed [23:0] lsound_out;
  logic signed [23:0] rsound_out;
  logic               sound_valid;
  logic               clip_l;
  logic               clip_r;
  logic               frame_err;

  int checks = 0;
  int errors = 0;

  // Sample history captured on every sound_valid high cycle
  int pulse_cnt = 0;
  int hist_l [64];
  int hist_r [64];

  mixer_3 dut (
    .sCLK_XVXENVS (sCLK_XVXENVS),
    .reset_data_N (reset_data_N),
    .slot_valid   (slot_valid),
    .slot_vx      (slot_vx),
    .slot_ox      (slot_ox),
    .sine_in      (sine_in),
    .level_mul    (level_mul),
    .reg_we       (reg_we),
    .reg_com_sel  (reg_com_sel),
    .reg_adr      (reg_adr),
    .reg_wdata    (reg_wdata),
    .flag_clr     (flag_clr),
    .lsound_out   (lsound_out),
    .rsound_out   (rsound_out),
    .sound_valid  (sound_valid),
    .clip_l       (clip_l),
    .clip_r       (clip_r),
    .frame_err    (frame_err)
  );

  initial begin
    sCLK_XVXENVS = 1'b0;
    forever #5 sCLK_XVXENVS = ~sCLK_XVXENVS;
  end

  always @(negedge sCLK_XVXENVS) begin
    if (sound_valid === 1'b1) begin
      if (pulse_cnt < 64) begin
        hist_l[pulse_cnt] = lsound_out;
        hist_r[pulse_cnt] = rsound_out;
      end
      pulse_cnt = pulse_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic reg_write(input bit com, input logic [6:0] adr, input logic [7:0] data);
    reg_we      = 1'b1;
    reg_com_sel = com;
    reg_adr     = adr;
    reg_wdata   = data;
    @(negedge sCLK_XVXENVS);
    reg_we      = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    @(negedge sCLK_XVXENVS);
    flag_clr = 1'b0;
    @(negedge sCLK_XVXENVS);
  endtask

  // One frame of 32 slots; slot index i = vx*4 + ox. Slots ia/ib carry
  // sine samples sa/sb, all others carry 0. drop skips one slot; gaps inserts
  // idle cycles inside the frame.
  task automatic send_frame(input int ia, input int sa, input int ib, input int sb,
                            input int lm, input int drop, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (i == drop) continue;
      if (gaps && (i % 5 == 3)) begin
        slot_valid = 1'b0;
        repeat (2) @(negedge sCLK_XVXENVS);
      end
      slot_valid = 1'b1;
      slot_vx    = 3'(i / 4);
      slot_ox    = 2'(i % 4);
      sine_in    = (i == ia) ? 17'(sa) : (i == ib) ? 17'(sb) : 17'sd0;
      level_mul  = 8'(lm);
      @(negedge sCLK_XVXENVS);
    end
    slot_valid = 1'b0;
    sine_in    = '0;
  endtask

  task automatic drain();
    repeat (8) @(negedge sCLK_XVXENVS);
  endtask

  // Single frame with expected sample and flag state
  task automatic frame_check(input string name, input int ia, input int sa,
                             input int ib, input int sb, input int drop,
                             input int exp_l, input int exp_r,
                             input bit exp_cl, input bit exp_cr, input bit exp_fe);
    int p0;
    p0 = pulse_cnt;
    send_frame(ia, sa, ib, sb, (name == "saturation" || name == "neg_saturation") ? 127 : 64,
               drop, 1'b0);
    drain();
    checks++;
    if (pulse_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL %s pulses: got %0d expected 1", name, pulse_cnt - p0);
    end
    checks++;
    if (lsound_out !== 24'(exp_l)) begin
      errors++;
      $display("FAIL %s lsound_out: got %0d expected %0d", name, lsound_out, exp_l);
    end
    checks++;
    if (rsound_out !== 24'(exp_r)) begin
      errors++;
      $display("FAIL %s rsound_out: got %0d expected %0d", name, rsound_out, exp_r);
    end
    checks++;
    if ({clip_l, clip_r, frame_err} !== {exp_cl, exp_cr, exp_fe}) begin
      errors++;
      $display("FAIL %s flags clip_l/clip_r/frame_err: got %b%b%b expected %b%b%b",
               name, clip_l, clip_r, frame_err, exp_cl, exp_cr, exp_fe);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    checks++;
    if ({lsound_out, rsound_out, sound_valid, clip_l, clip_r, frame_err} !== 52'd0) begin
      errors++;
      $display("FAIL reset outputs: got l=%0d r=%0d v=%b flags=%b%b%b expected all 0",
               lsound_out, rsound_out, sound_valid, clip_l, clip_r, frame_err);
    end
    @(negedge sCLK_XVXENVS);
    reset_data_N = 1'b1;
    @(negedge sCLK_XVXENVS);
  endtask

  task automatic test_single();
    // Writes to unmapped addresses must not disturb anything.
    reg_write(1'b0, 7'h03, 8'h00);
    reg_write(1'b1, 7'h02, 8'h00);
    reg_write(1'b1, 7'h07, 8'h00);
    reg_write(1'b0, 7'h42, 8'h00);
    reg_write(1'b0, 7'h02, 8'd64);
    reg_write(1'b0, 7'h07, 8'd64);
    reg_write(1'b1, 7'h01, 8'd64);
    frame_check("single", 0, 1000, -1, 0, -1, 7875, 8000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_negative();
    frame_check("negative", 0, -1000, -1, 0, -1, -7875, -8000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pan_clamp();
    reg_write(1'b0, 7'h07, 8'd200);
    frame_check("pan_clamp", 0, 1000, -1, 0, -1, 0, 15875, 1'b0, 1'b0, 1'b0);
    reg_write(1'b0, 7'h07, 8'd64);
  endtask

  task automatic test_saturation();
    reg_write(1'b0, 7'h02, 8'd127);
    reg_write(1'b0, 7'h07, 8'd0);
    reg_write(1'b1, 7'h01, 8'd127);
    frame_check("saturation", 0, 65535, 4, 65535, -1, 8388607, 0, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    checks++;
    if (clip_l !== 1'b0) begin
      errors++;
      $display("FAIL clip_l after flag_clr: got %b expected 0", clip_l);
    end
    frame_check("neg_saturation", 0, -65535, 4, -65535, -1, -8388608, 0, 1'b1, 1'b0, 1'b0);
    pulse_clr();
    reg_write(1'b0, 7'h02, 8'd64);
    reg_write(1'b0, 7'h07, 8'd64);
    reg_write(1'b1, 7'h01, 8'd64);
  endtask

  task automatic test_short_frame();
    frame_check("short_frame", 0, 1000, -1, 0, 5, 7875, 8000, 1'b0, 1'b0, 1'b1);
    pulse_clr();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err after flag_clr: got %b expected 0", frame_err);
    end
    frame_check("full_after_short", 0, 1000, -1, 0, -1, 7875, 8000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    // osc 0 and osc 1 both at level 64, pan 64: sum 6144000*63*64 / 2^21 = 11812.5
    send_frame(0, 1000, 1, 500, 64, -1, 1'b0);
    send_frame(0, 1000, 1, 500, 64, -1, 1'b1);
    drain();
    checks++;
    if (pulse_cnt - p0 !== 2) begin
      errors++;
      $display("FAIL back_to_back pulses: got %0d expected 2", pulse_cnt - p0);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (hist_l[p0+k] !== 11812 || hist_r[p0+k] !== 12000) begin
        errors++;
        $display("FAIL back_to_back frame %0d: got l=%0d r=%0d expected l=11812 r=12000",
                 k, hist_l[p0+k], hist_r[p0+k]);
      end
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back frame_err: got %b expected 0", frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    int p0;
    reg_write(1'b0, 7'h22, 8'd100);
    for (int i = 0; i < 10; i++) begin
      slot_valid = 1'b1;
      slot_vx    = 3'(i / 4);
      slot_ox    = 2'(i % 4);
      sine_in    = 17'sd2000;
      level_mul  = 8'sd64;
      @(negedge sCLK_XVXENVS);
    end
    slot_valid = 1'b0;
    #2 reset_data_N = 1'b0;
    #1;
    checks++;
    if ({lsound_out, rsound_out, sound_valid, clip_l, clip_r, frame_err} !== 52'd0) begin
      errors++;
      $display("FAIL midframe reset outputs: got l=%0d r=%0d v=%b flags=%b%b%b expected all 0",
               lsound_out, rsound_out, sound_valid, clip_l, clip_r, frame_err);
    end
    @(negedge sCLK_XVXENVS);
    reset_data_N = 1'b1;
    @(negedge sCLK_XVXENVS);
    p0 = pulse_cnt;
    // osc 2 level back to default 0, so its large sample contributes nothing.
    frame_check("after_reset", 0, 1000, 2, 30000, -1, 7875, 8000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hist_l[p0] !== 7875) begin
      errors++;
      $display("FAIL after_reset captured sample: got %0d expected 7875", hist_l[p0]);
    end
  endtask

  initial begin
    reset_data_N = 1'b0;
    slot_valid   = 1'b0;
    slot_vx      = '0;
    slot_ox      = '0;
    sine_in      = '0;
    level_mul    = '0;
    reg_we       = 1'b0;
    reg_com_sel  = 1'b0;
    reg_adr      = '0;
    reg_wdata    = '0;
    flag_clr     = 1'b0;

    test_reset();
    test_single();
    test_negative();
    test_pan_clamp();
    test_saturation();
    test_short_frame();
    test_back_to_back();
    test_reset_midframe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
